// File: rtl/encoder8x3_pend.sv
// Registered 8-to-3 priority encoder: edge-captures request lines into a pending set
// and drains it one code at a time over a valid/ready handshake.
module encoder8x3_pend #(
    parameter int unsigned PRIO_HIGH = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       m1,
    input  logic       m2,
    input  logic       m3,
    input  logic       m4,
    input  logic       m5,
    input  logic       m6,
    input  logic       m7,
    input  logic       m8,
    input  logic       RDY,
    output logic       V,
    output logic       I1,
    output logic       I2,
    output logic       I3,
    output logic       OVF,
    output logic [3:0] CNT
);

    logic [7:0] m_vec;
    logic [7:0] prev_q;
    logic [7:0] pend_q, pend_d;
    logic [7:0] rise;
    logic [7:0] sel_oh;
    logic [2:0] sel_idx;
    logic [2:0] code_q, code_d;
    logic       v_q, v_d;
    logic       ovf_q, ovf_d;
    logic       load;
    logic       take;

    assign m_vec = {m8, m7, m6, m5, m4, m3, m2, m1};
    assign rise  = m_vec & ~prev_q;
    assign load  = ~v_q | RDY;
    assign take  = load & (|pend_q);

    // Later iterations overwrite earlier ones, so loop direction sets the winner.
    always_comb begin
        sel_idx = 3'd0;
        if (PRIO_HIGH != 0) begin
            for (int k = 0; k < 8; k++) begin
                if (pend_q[k]) sel_idx = 3'(k);
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (pend_q[k]) sel_idx = 3'(k);
            end
        end
    end

    always_comb begin
        sel_oh = 8'd0;
        if (take) sel_oh = 8'd1 << sel_idx;
    end

    always_comb begin
        pend_d = (pend_q & ~sel_oh) | (EN ? rise : 8'd0);
        ovf_d  = EN & (|(rise & pend_q & ~sel_oh));
        v_d    = v_q;
        code_d = code_q;
        if (load) begin
            v_d = |pend_q;
            if (take) code_d = sel_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q <= 8'd0;
            pend_q <= 8'd0;
            v_q    <= 1'b0;
            code_q <= 3'd0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= m_vec;
            pend_q <= pend_d;
            v_q    <= v_d;
            code_q <= code_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        CNT = 4'd0;
        for (int k = 0; k < 8; k++) begin
            CNT = CNT + 4'(pend_q[k]);
        end
    end

    assign V   = v_q;
    assign I1  = code_q[2];
    assign I2  = code_q[1];
    assign I3  = code_q[0];
    assign OVF = ovf_q;

endmodule

// File: tb/tb_encoder8x3_pend.sv
// Directed self-checking bench for encoder8x3_pend; runs both priority orders side by side.
module tb_encoder8x3_pend;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b1;
    logic       RDY = 1'b1;
    logic [7:0] mv  = 8'd0;

    logic       v_h, i1_h, i2_h, i3_h, ovf_h;
    logic [3:0] cnt_h;
    logic       v_l, i1_l, i2_l, i3_l, ovf_l;
    logic [3:0] cnt_l;
    logic [2:0] code_h, code_l;

    int errors = 0;
    int checks = 0;
    int xfer [8];
    int sum_before;

    assign code_h = {i1_h, i2_h, i3_h};
    assign code_l = {i1_l, i2_l, i3_l};

    always #5 CLK = ~CLK;

    encoder8x3_pend #(.PRIO_HIGH(1)) dut_hi (
        .CLK(CLK), .RST(RST), .EN(EN),
        .m1(mv[0]), .m2(mv[1]), .m3(mv[2]), .m4(mv[3]),
        .m5(mv[4]), .m6(mv[5]), .m7(mv[6]), .m8(mv[7]),
        .RDY(RDY), .V(v_h), .I1(i1_h), .I2(i2_h), .I3(i3_h), .OVF(ovf_h), .CNT(cnt_h)
    );

    encoder8x3_pend #(.PRIO_HIGH(0)) dut_lo (
        .CLK(CLK), .RST(RST), .EN(EN),
        .m1(mv[0]), .m2(mv[1]), .m3(mv[2]), .m4(mv[3]),
        .m5(mv[4]), .m6(mv[5]), .m7(mv[6]), .m8(mv[7]),
        .RDY(RDY), .V(v_l), .I1(i1_l), .I2(i2_l), .I3(i3_l), .OVF(ovf_l), .CNT(cnt_l)
    );

    // Codes actually consumed by the high-priority instance.
    always @(posedge CLK) begin
        if (!RST && v_h && RDY) xfer[code_h] <= xfer[code_h] + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input int v, input int code, input int cnt);
        check({tag, " V"}, int'(v_h), v);
        if (v != 0) check({tag, " code"}, int'(code_h), code);
        check({tag, " CNT"}, int'(cnt_h), cnt);
    endtask

    function automatic int xfer_sum();
        int s = 0;
        for (int k = 0; k < 8; k++) s += xfer[k];
        return s;
    endfunction

    initial begin
        // Reset with every line high and capture enabled.
        RST = 1'b1; EN = 1'b1; RDY = 1'b1; mv = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst V", int'(v_h), 0);
            check("rst code", int'(code_h), 0);
            check("rst CNT", int'(cnt_h), 0);
            check("rst OVF", int'(ovf_h), 0);
        end
        RST = 1'b0;
        tick();
        mv = 8'h00;
        chk_out("post-rst capture", 0, 0, 8);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("drain all", 1, 7 - i, 7 - i);
        end
        tick();
        check("drain all done V", int'(v_h), 0);

        // Single request on m6.
        mv = 8'b0010_0000;
        tick();
        mv = 8'h00;
        chk_out("single pend", 0, 0, 1);
        tick();
        chk_out("single out", 1, 5, 0);
        tick();
        check("single done V", int'(v_h), 0);

        // Priority and backpressure: m1, m4, m8 together.
        RDY = 1'b0;
        mv = 8'b1000_1001;
        tick();
        mv = 8'h00;
        check("prio capture CNT", int'(cnt_h), 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("prio hold hi", 1, 7, 2);
            check("prio hold lo V", int'(v_l), 1);
            check("prio hold lo code", int'(code_l), 0);
        end
        RDY = 1'b1;
        tick();
        chk_out("prio 2nd hi", 1, 3, 1);
        check("prio 2nd lo code", int'(code_l), 3);
        tick();
        chk_out("prio 3rd hi", 1, 0, 0);
        check("prio 3rd lo code", int'(code_l), 7);
        tick();
        check("prio done hi V", int'(v_h), 0);
        check("prio done lo V", int'(v_l), 0);

        // Overflow on m3.
        sum_before = xfer[2];
        RDY = 1'b0;
        mv = 8'b0000_0100;
        tick();
        mv = 8'h00;
        tick();
        chk_out("ovf first load", 1, 2, 0);
        tick();
        mv = 8'b0000_0100;
        tick();
        mv = 8'h00;
        chk_out("ovf second pend", 1, 2, 1);
        check("ovf second OVF", int'(ovf_h), 0);
        tick();
        mv = 8'b0000_0100;
        tick();
        mv = 8'h00;
        check("ovf third OVF", int'(ovf_h), 1);
        check("ovf third CNT", int'(cnt_h), 1);
        tick();
        check("ovf pulse width", int'(ovf_h), 0);
        RDY = 1'b1;
        tick();
        chk_out("ovf drain", 1, 2, 0);
        tick();
        check("ovf drain done V", int'(v_h), 0);
        check("ovf two codes", xfer[2] - sum_before, 2);

        // Same-cycle select and new rise on m5.
        sum_before = xfer[4];
        RDY = 1'b0;
        mv = 8'b0000_0001;
        tick();
        mv = 8'h00;
        tick();
        mv = 8'b0001_0000;
        tick();
        mv = 8'h00;
        tick();
        chk_out("same pend", 1, 0, 1);
        mv = 8'b0001_0000;
        RDY = 1'b1;
        tick();
        mv = 8'h00;
        chk_out("same select", 1, 4, 1);
        check("same no OVF", int'(ovf_h), 0);
        tick();
        chk_out("same second", 1, 4, 0);
        tick();
        check("same done V", int'(v_h), 0);
        check("same two codes", xfer[4] - sum_before, 2);

        // Capture disabled: m2 pulse is dropped.
        EN = 1'b0;
        mv = 8'b0000_0010;
        tick();
        mv = 8'h00;
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("en masked", 0, 0, 0);
        end

        // Reset mid-stream drops everything.
        RDY = 1'b0;
        mv = 8'b0100_1011;
        tick();
        mv = 8'h00;
        tick();
        chk_out("mid pend", 1, 6, 3);
        sum_before = xfer_sum();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        RDY = 1'b1;
        chk_out("mid rst", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("mid after", 0, 0, 0);
        end
        check("mid no codes", xfer_sum() - sum_before, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder8x3_pend.md
# encoder8x3_pend

Registered 8-to-3 priority encoder with a pending-request store, the counterpart of the 3x8 decoder. One-hot/minterm lines m1..m8, matching the decoder's output names, are edge-captured into a pending set. The block then drains that set one 3-bit code at a time over a valid/ready handshake, on I1 I2 I3, which match the decoder's input names. It sits between eight independent event sources and a single consumer that regenerates the minterm through the decoder.

## Interface
Parameters:
- PRIO_HIGH, default 1. Selects which pending line drains first:
  - 1: highest index first (m8 first).
  - 0: lowest index first (m1 first).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  capture enable; gates capture of new requests only.
- m1..m8  in  1 each  request lines; mk maps to code k-1.
- RDY  in  1  consumer ready.
- V  out  1  output code valid.
- I1, I2, I3  out  1 each  encoded index, I1 = MSB, I3 = LSB (m1 → 000, m8 → 111).
- OVF  out  1  one-cycle pulse: a request was lost by merging into an already-pending line.
- CNT  out  4  number of pending lines, 0..8. Excludes the code held on the outputs.

## Operation
- State:
  - prev[8]: last sampled m.
  - P[8]: pending set.
  - Output slot: V and the code {I1,I2,I3}.
  - OVF register.
- Edge detect: rise[k] = m[k] & ~prev[k]. prev updates every cycle regardless of EN.
- Capture: when EN=1, every rising line is set in P. When EN=0, rising edges are discarded and never replayed.
- Slot load condition: load = (V==0) | (V & RDY).
  - When load and P≠0: select the priority line s of the current P (per PRIO_HIGH). The code for s goes to {I1,I2,I3}, V goes to 1, and bit s is cleared from P.
  - When load and P==0: V goes to 0. The code holds its last value; it is don't-care while V=0.
- P update, all in one cycle: P_next = (P & ~sel_onehot) | (EN ? rise : 0).
  - Clear happens before set. A rise on line s in the same cycle that s is selected leaves s pending. This is a new request, not an overflow.
- Overflow: OVF_next = EN & |(rise & P & ~sel_onehot). The request is merged, so exactly one code is eventually output for it.
- CNT is the popcount of the registered P.
- While V=1 and RDY=0:
  - V and the code are held stable.
  - P keeps capturing.
- A level held high produces exactly one request. It must fall and rise again to request again.

## Timing
- Reset (RST=1 at a rising edge) dominates EN, m and RDY. It forces:
  - prev=0, P=0, V=0, {I1,I2,I3}=000, OVF=0, CNT=0.
- Lines held high through reset produce rise=1 on the first cycle after release. They are captured only if EN=1 in that cycle.
- Reset mid-operation: all pending requests and any held code are dropped. No output is produced for them.
- Latency: m rises before edge n, P is set at edge n, and V=1 with its code appears after edge n+1, assuming the slot is empty or being accepted. Minimum request-to-V latency is 2 cycles.
- Throughput: one code per cycle while RDY=1 and P≠0. V stays continuously high.
- Transfer: a code is consumed at the edge where V=1 and RDY=1.
- OVF is visible the cycle after the offending edge, and is 1 cycle wide.
- CNT reflects P one cycle after capture or selection.
- Boundaries:
  - All eight lines pending: CNT=8. Further rises set OVF and never increment CNT.
  - P empty with RDY=1: V drops the cycle after the last transfer.

## Test plan
- Reset: hold RST=1 for 2 cycles with m=all 1 and EN=1.
  - During reset: V=0, code 000, CNT=0, OVF=0.
  - First cycle after release: all 8 captured, CNT=8 one cycle later.
  - With RDY=1 and PRIO_HIGH=1, codes come out 111,110,…,000 in 8 consecutive cycles, then V=0.
- Single request: EN=1, RDY=1, pulse m6 for 1 cycle.
  - V=1 with I1I2I3=101 exactly 2 cycles later, for exactly 1 cycle.
  - CNT goes 0→1→0.
- Priority and backpressure: RDY=0, one-cycle pulse of m1, m4 and m8 together.
  - V=1 with 111 held for 5 cycles; CNT=2.
  - Raise RDY: codes 111, 011, 000 on consecutive cycles, then V=0.
  - Repeat with PRIO_HIGH=0: expected order 000, 011, 111.
- Overflow: RDY=0, pulse m3 twice, 3 cycles apart.
  - The first pulse is loaded into the empty slot (V=1, code 010) and cleared from P (CNT=0).
  - The second pulse sets P[2] (CNT=1).
  - Pulse m3 a third time: OVF=1 for exactly 1 cycle; CNT stays 1.
  - After RDY=1: exactly two 010 codes total.
- Same-cycle select and rise: m5 pending and being selected, with a new m5 rise in that cycle.
  - No OVF; m5 remains pending.
  - Two 100 codes are output in total.
- EN masking and reset mid-stream:
  - EN=0 while pulsing m2: V stays 0, CNT=0.
  - With 3 lines pending and V=1, assert RST for 1 cycle: V=0, CNT=0 the next cycle, and no further codes appear.
